// File: rtl/ysyx_201979054_axi_burst_ctrl.sv
// AXI4 burst master that moves whole cache lines between the line shift-buffer
// and memory. A refill issues one INCR read burst and shifts every R beat into
// the buffer; a writeback issues one INCR write burst and shifts the buffer out
// one beat per W handshake. Channel valids/readies are decoded from the state
// register, while the buffer shift strobe follows the live handshake so each
// beat moves in the same cycle it is transferred.
module ysyx_201979054_axi_burst_ctrl #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int BLOCK_WIDTH    = 512
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        i_fill_req,
    input  logic                        i_wb_req,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err,
    output logic                        o_fifo_write_en,
    output logic                        o_start_read,
    output logic                        o_start_write,
    output logic                        o_arvalid,
    input  logic                        i_arready,
    output logic [AXI_ADDR_WIDTH-1:0]   o_araddr,
    output logic [7:0]                  o_arlen,
    output logic [2:0]                  o_arsize,
    output logic [1:0]                  o_arburst,
    input  logic                        i_rvalid,
    output logic                        o_rready,
    input  logic                        i_rlast,
    input  logic [1:0]                  i_rresp,
    output logic                        o_awvalid,
    input  logic                        i_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   o_awaddr,
    output logic [7:0]                  o_awlen,
    output logic [2:0]                  o_awsize,
    output logic [1:0]                  o_awburst,
    output logic                        o_wvalid,
    input  logic                        i_wready,
    output logic                        o_wlast,
    output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
    input  logic                        i_bvalid,
    output logic                        o_bready,
    input  logic [1:0]                  i_bresp
);

    localparam int BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
    localparam int OFFS  = $clog2(BLOCK_WIDTH / 8);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CW-1:0]             LAST_BEAT = CW'(BEATS - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] OFFS_MASK = AXI_ADDR_WIDTH'((64'd1 << OFFS) - 64'd1);
    localparam logic [2:0]                BEAT_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW,
        W,
        B,
        DONE
    } state_t;

    state_t                    state;
    logic [CW-1:0]             beat_cnt;
    logic [AXI_ADDR_WIDTH-1:0] line_addr;
    logic                      err;
    logic                      is_wb;

    // Burst sequencing: accept a request in IDLE, walk the AXI channels in order,
    // accumulate sticky error status and finish with a one-cycle DONE.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            line_addr <= '0;
            err       <= 1'b0;
            is_wb     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_wb_req) begin
                        state     <= AW;
                        is_wb     <= 1'b1;
                        line_addr <= i_addr & ~OFFS_MASK;
                        beat_cnt  <= '0;
                        err       <= 1'b0;
                    end else if (i_fill_req) begin
                        state     <= AR;
                        is_wb     <= 1'b0;
                        line_addr <= i_addr & ~OFFS_MASK;
                        beat_cnt  <= '0;
                        err       <= 1'b0;
                    end
                end
                AR: begin
                    if (i_arready) begin
                        state <= R;
                    end
                end
                R: begin
                    if (i_rvalid) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if ((i_rresp != 2'b00) || (i_rlast != (beat_cnt == LAST_BEAT))) begin
                            err <= 1'b1;
                        end
                        if (i_rlast || (beat_cnt == LAST_BEAT)) begin
                            state <= DONE;
                        end
                    end
                end
                AW: begin
                    if (i_awready) begin
                        state <= W;
                    end
                end
                W: begin
                    if (i_wready) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state <= B;
                        end
                    end
                end
                B: begin
                    if (i_bvalid) begin
                        if (i_bresp != 2'b00) begin
                            err <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy          = (state != IDLE);
    assign o_done          = (state == DONE);
    assign o_err           = err;
    assign o_fifo_write_en = ((state == R) && i_rvalid) || ((state == W) && i_wready);
    assign o_start_read    = (state == AR) || (state == R) || ((state == DONE) && !is_wb);
    assign o_start_write   = (state == AW) || (state == W) || (state == B) || ((state == DONE) && is_wb);

    assign o_arvalid = (state == AR);
    assign o_araddr  = line_addr;
    assign o_arlen   = 8'(BEATS - 1);
    assign o_arsize  = BEAT_SIZE;
    assign o_arburst = 2'b01;
    assign o_rready  = (state == R);

    assign o_awvalid = (state == AW);
    assign o_awaddr  = line_addr;
    assign o_awlen   = 8'(BEATS - 1);
    assign o_awsize  = BEAT_SIZE;
    assign o_awburst = 2'b01;
    assign o_wvalid  = (state == W);
    assign o_wlast   = (state == W) && (beat_cnt == LAST_BEAT);
    assign o_wstrb   = {(AXI_DATA_WIDTH / 8){1'b1}};
    assign o_bready  = (state == B);

endmodule

// File: tb/tb_ysyx_201979054_axi_burst_ctrl.sv
// Self-checking bench for the AXI line burst controller. A randomized AXI slave
// drives the channels while a transaction-level model predicts which channel
// should be active, how many beats the buffer shifts and the final error flag.
module tb_ysyx_201979054_axi_burst_ctrl;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        i_fill_req, i_wb_req;
    logic [31:0] i_addr;
    logic        o_busy, o_done, o_err, o_fifo_write_en, o_start_read, o_start_write;
    logic        o_arvalid, i_arready;
    logic [31:0] o_araddr;
    logic [7:0]  o_arlen;
    logic [2:0]  o_arsize;
    logic [1:0]  o_arburst;
    logic        i_rvalid, o_rready, i_rlast;
    logic [1:0]  i_rresp;
    logic        o_awvalid, i_awready;
    logic [31:0] o_awaddr;
    logic [7:0]  o_awlen;
    logic [2:0]  o_awsize;
    logic [1:0]  o_awburst;
    logic        o_wvalid, i_wready, o_wlast;
    logic [3:0]  o_wstrb;
    logic        i_bvalid, o_bready;
    logic [1:0]  i_bresp;

    int total = 0;
    int bad   = 0;

    logic [1:0] rresp_tab [16];
    logic       rlast_tab [16];

    typedef struct {
        logic        wb;
        logic        fill;
        logic [31:0] addr;
        logic        exp_ar;
        logic        exp_aw;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [5];

    ysyx_201979054_axi_burst_ctrl dut (
        .clk(clk), .arst(arst),
        .i_fill_req(i_fill_req), .i_wb_req(i_wb_req), .i_addr(i_addr),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_fifo_write_en(o_fifo_write_en), .o_start_read(o_start_read), .o_start_write(o_start_write),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arlen(o_arlen),
        .o_arsize(o_arsize), .o_arburst(o_arburst),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rlast(i_rlast), .i_rresp(i_rresp),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awlen(o_awlen),
        .o_awsize(o_awsize), .o_awburst(o_awburst),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wlast(o_wlast), .o_wstrb(o_wstrb),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp)
    );

    // Free-running clock, active edge is posedge.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        i_fill_req = 1'b0; i_wb_req = 1'b0; i_addr = 32'h0;
        i_arready = 1'b0; i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00;
        i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
    endtask

    task automatic fill_rtab(input int last_idx, input int err_idx, input logic [1:0] err_val);
        for (int i = 0; i < 16; i++) begin
            rresp_tab[i] = (i == err_idx) ? err_val : 2'b00;
            rlast_tab[i] = (i == last_idx);
        end
    endtask

    // One complete transaction against a randomized slave. Expected channel
    // activity comes from handshake counts, not from the DUT's state.
    task automatic run_txn(input bit is_wb, input bit hold_fill, input bit toggle_w,
                           input logic [31:0] addr, input logic [1:0] bresp);
        int   acc, r_cnt, w_cnt, we_cnt, idx;
        bit   exp_err, ar_done, aw_done, b_sent, done_seen;
        bit   exp_arv, exp_rr, exp_awv, exp_wv, exp_br, exp_done;
        logic [31:0] exp_addr;
        exp_addr = addr & 32'hFFFF_FFC0;
        r_cnt = 0; w_cnt = 0; we_cnt = 0;
        ar_done = 0; aw_done = 0; b_sent = 0; done_seen = 0;
        if (is_wb) begin
            acc = 16;
            exp_err = (bresp != 2'b00);
        end else begin
            acc = 16;
            for (int i = 0; i < 16; i++) begin
                if (rlast_tab[i]) begin
                    acc = i + 1;
                    break;
                end
            end
            exp_err = !rlast_tab[15] || (acc != 16);
            for (int i = 0; i < acc; i++) begin
                if (rresp_tab[i] != 2'b00) exp_err = 1;
            end
        end

        i_wb_req = is_wb; i_fill_req = !is_wb || hold_fill; i_addr = addr;
        @(posedge clk); #1;
        i_wb_req = 1'b0; i_fill_req = hold_fill;

        for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            idx = (r_cnt < 16) ? r_cnt : 0;
            i_arready = 1'($urandom_range(0, 1));
            i_awready = 1'($urandom_range(0, 1));
            i_rvalid  = (!is_wb && ar_done && r_cnt < acc) ? ($urandom_range(0, 2) != 0) : 1'b0;
            i_rresp   = rresp_tab[idx];
            i_rlast   = rlast_tab[idx];
            i_wready  = toggle_w ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            i_bvalid  = (is_wb && w_cnt == 16 && !b_sent) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_bresp   = bresp;
            #1;
            exp_arv  = !is_wb && !ar_done;
            exp_rr   = !is_wb && ar_done && (r_cnt < acc);
            exp_awv  = is_wb && !aw_done;
            exp_wv   = is_wb && aw_done && (w_cnt < 16);
            exp_br   = is_wb && (w_cnt == 16) && !b_sent;
            exp_done = is_wb ? b_sent : (r_cnt == acc);
            check_output("arvalid", o_arvalid, exp_arv);
            check_output("rready", o_rready, exp_rr);
            check_output("awvalid", o_awvalid, exp_awv);
            check_output("wvalid", o_wvalid, exp_wv);
            check_output("bready", o_bready, exp_br);
            check_output("done", o_done, exp_done);
            check_output("busy", o_busy, 1);
            check_output("start_read", o_start_read, !is_wb);
            check_output("start_write", o_start_write, is_wb);
            check_output("write_en", o_fifo_write_en, (exp_rr && i_rvalid) || (exp_wv && i_wready));
            if (exp_arv) begin
                check_output("araddr", o_araddr, exp_addr);
                check_output("arlen", o_arlen, 15);
                check_output("arsize", o_arsize, 2);
                check_output("arburst", o_arburst, 1);
            end
            if (exp_awv) begin
                check_output("awaddr", o_awaddr, exp_addr);
                check_output("awlen", o_awlen, 15);
                check_output("awsize", o_awsize, 2);
                check_output("awburst", o_awburst, 1);
            end
            if (exp_wv) begin
                check_output("wlast", o_wlast, (w_cnt == 15));
                check_output("wstrb", o_wstrb, 4'hF);
            end
            if (exp_done) begin
                done_seen = 1;
                check_output("err", o_err, exp_err);
            end
            if (o_fifo_write_en) we_cnt++;
            if (exp_arv && i_arready) ar_done = 1;
            if (exp_awv && i_awready) aw_done = 1;
            if (exp_rr && i_rvalid) r_cnt++;
            if (exp_wv && i_wready) w_cnt++;
            if (exp_br && i_bvalid) b_sent = 1;
            if (!done_seen) begin
                @(posedge clk); #1;
            end
        end
        if (!done_seen) check_output("txn_timeout", 0, 1);
        check_output("write_en_count", we_cnt, acc);

        i_arready = 1'b0; i_awready = 1'b0; i_rvalid = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
        @(posedge clk); #1; #1;
        check_output("done_one_cycle", o_done, 0);
        check_output("idle_after_done", o_busy, 0);
    endtask

    // Table-driven request arbitration from IDLE, each vector undone by a reset pulse.
    task automatic apply_stimulus();
        vecs[0] = '{wb: 1'b0, fill: 1'b1, addr: 32'h8000_1234, exp_ar: 1'b1, exp_aw: 1'b0, exp_addr: 32'h8000_1200};
        vecs[1] = '{wb: 1'b1, fill: 1'b0, addr: 32'h1234_567F, exp_ar: 1'b0, exp_aw: 1'b1, exp_addr: 32'h1234_5640};
        vecs[2] = '{wb: 1'b1, fill: 1'b1, addr: 32'hFFFF_FFFF, exp_ar: 1'b0, exp_aw: 1'b1, exp_addr: 32'hFFFF_FFC0};
        vecs[3] = '{wb: 1'b0, fill: 1'b0, addr: 32'hDEAD_BEEF, exp_ar: 1'b0, exp_aw: 1'b0, exp_addr: 32'h0};
        vecs[4] = '{wb: 1'b0, fill: 1'b1, addr: 32'h0000_003F, exp_ar: 1'b1, exp_aw: 1'b0, exp_addr: 32'h0000_0000};
        for (int v = 0; v < 5; v++) begin
            i_wb_req = vecs[v].wb; i_fill_req = vecs[v].fill; i_addr = vecs[v].addr;
            @(posedge clk); #1;
            i_wb_req = 1'b0; i_fill_req = 1'b0;
            #1;
            check_output("vec_arvalid", o_arvalid, vecs[v].exp_ar);
            check_output("vec_awvalid", o_awvalid, vecs[v].exp_aw);
            check_output("vec_busy", o_busy, vecs[v].exp_ar | vecs[v].exp_aw);
            if (vecs[v].exp_ar) check_output("vec_araddr", o_araddr, vecs[v].exp_addr);
            if (vecs[v].exp_aw) check_output("vec_awaddr", o_awaddr, vecs[v].exp_addr);
            arst = 1'b1; #1; arst = 1'b0;
        end
    endtask

    initial begin
        int hs;
        logic [31:0] raddr;
        bit rwb;
        clear_inputs();
        arst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy", o_busy, 0);
        check_output("rst_done", o_done, 0);
        check_output("rst_err", o_err, 0);
        check_output("rst_valids", {o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready}, 0);
        check_output("rst_strobes", {o_fifo_write_en, o_start_read, o_start_write}, 0);
        check_output("rst_addr", o_araddr, 0);
        arst = 1'b0;

        apply_stimulus();

        $display("[TB] refill, clean burst");
        fill_rtab(15, -1, 2'b00);
        run_txn(0, 0, 0, 32'h8000_1234, 2'b00);

        $display("[TB] writeback, toggling wready");
        run_txn(1, 0, 1, 32'h8000_4480, 2'b00);

        $display("[TB] both requests, writeback first then fill");
        run_txn(1, 1, 0, 32'h0000_1000, 2'b00);
        run_txn(0, 0, 0, 32'h0000_1000, 2'b00);

        $display("[TB] refill with SLVERR on beat 5");
        fill_rtab(15, 5, 2'b10);
        run_txn(0, 0, 0, 32'h2000_0040, 2'b00);

        $display("[TB] refill with early rlast");
        fill_rtab(9, -1, 2'b00);
        run_txn(0, 0, 0, 32'h3000_0000, 2'b00);

        $display("[TB] writeback with error response");
        run_txn(1, 0, 0, 32'h4000_00C0, 2'b10);

        $display("[TB] reset mid write burst");
        i_wb_req = 1'b1; i_addr = 32'h5000_0000;
        @(posedge clk); #1;
        i_wb_req = 1'b0; i_awready = 1'b1; i_wready = 1'b1;
        hs = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (o_wvalid && i_wready) begin
                if (hs == 7) break;
                hs++;
            end
        end
        check_output("beat7_reached", hs, 7);
        arst = 1'b1; #1;
        check_output("arst_wvalid", o_wvalid, 0);
        check_output("arst_start_write", o_start_write, 0);
        check_output("arst_busy", o_busy, 0);
        check_output("arst_write_en", o_fifo_write_en, 0);
        clear_inputs();
        @(posedge clk); #1;
        arst = 1'b0;
        fill_rtab(15, -1, 2'b00);
        run_txn(0, 0, 0, 32'h5000_0010, 2'b00);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 10; t++) begin
            rwb   = 1'($urandom_range(0, 1));
            raddr = $urandom;
            fill_rtab(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 15,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                      2'($urandom_range(1, 3)));
            run_txn(rwb, 0, 0, raddr, ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_201979054_axi_burst_ctrl.md
Name: ysyx_201979054_axi_burst_ctrl

Overview:
- AXI4 burst master FSM that moves whole cache lines between the cache and memory.
- Drives the line shift-buffer control pins (write_en, start_read, start_write).
- Refill: issues an INCR read burst and shifts each R beat into the buffer.
- Writeback: issues an INCR write burst and shifts the buffer out one beat per W handshake.
- Sits between the cache controller and the AXI master port.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 32, beat width in bits; power of two, >= 8.
- BLOCK_WIDTH, 512, cache line width in bits; integer multiple of AXI_DATA_WIDTH.
- Derived: BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH (16); OFFS = log2(BLOCK_WIDTH/8) (6).

Ports:
- clk  in  1  clock
- arst  in  1  reset, asynchronous, active-high
- i_fill_req  in  1  request line refill; sampled only in IDLE
- i_wb_req  in  1  request line writeback; sampled only in IDLE
- i_addr  in  AXI_ADDR_WIDTH  line address
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse when the transfer completes
- o_err  out  1  error status of the last transfer; valid with o_done
- o_fifo_write_en  out  1  buffer shift strobe
- o_start_read  out  1  buffer in refill mode
- o_start_write  out  1  buffer in writeback mode
- o_arvalid out 1; i_arready in 1; o_araddr out AXI_ADDR_WIDTH; o_arlen out 8; o_arsize out 3; o_arburst out 2
- i_rvalid in 1; o_rready out 1; i_rlast in 1; i_rresp in 2
- o_awvalid out 1; i_awready in 1; o_awaddr out AXI_ADDR_WIDTH; o_awlen out 8; o_awsize out 3; o_awburst out 2
- o_wvalid out 1; i_wready in 1; o_wlast out 1; o_wstrb out AXI_DATA_WIDTH/8
- i_bvalid in 1; o_bready out 1; i_bresp in 2

Behaviour:
- States: IDLE, AR, R, AW, W, B, DONE. Registered state and beat counter (log2(BEATS) bits).
- Reset: state=IDLE, counter=0, latched address=0, o_err=0. All valid/ready/strobe outputs and o_done are 0.
- IDLE:
  - i_wb_req -> AW. i_wb_req has priority when both requests are high.
  - Else i_fill_req -> AR.
  - On acceptance, latch i_addr with its low OFFS bits cleared, clear counter and err.
  - o_start_read = o_start_write = 0, so the buffer parallel-loads the block every IDLE cycle.
- AR: o_arvalid=1, held until i_arready; then -> R.
- R:
  - o_rready=1.
  - Each i_rvalid: o_fifo_write_en=1 (combinational, same cycle), counter++.
  - Any rresp != 0 sets err (sticky).
  - i_rlast on a beat with counter != BEATS-1, or no rlast on beat BEATS-1: set err.
  - Exit to DONE on the beat with i_rlast or counter==BEATS-1, whichever comes first.
- AW: o_awvalid=1 until i_awready; then -> W. W is never issued before the AW handshake.
- W:
  - o_wvalid=1, o_wstrb all ones.
  - o_wlast = (counter==BEATS-1).
  - Each i_wready: o_fifo_write_en=1 (shifts the next beat onto the buffer output), counter++.
  - After the last-beat handshake -> B.
- B: o_bready=1. On i_bvalid, err |= (bresp != 0); -> DONE.
- DONE: o_done=1 for one cycle, o_err holds; o_start_* still asserted (refilled block stable); -> IDLE.
- Mode outputs:
  - o_start_read = state in {AR, R, DONE-after-fill}.
  - o_start_write = state in {AW, W, B, DONE-after-wb}.
  - Never both high.
- Fixed AXI fields: arlen = awlen = BEATS-1; arsize = awsize = log2(AXI_DATA_WIDTH/8); burst = 2'b01 (INCR).
- AXI valids never drop before their handshake. Requests arriving while busy are ignored, with no queuing.
- arst mid-burst: immediate return to IDLE with all outputs cleared. No attempt to complete the burst.
- Counter wraps naturally; BEATS must be a power of two.

Test Plan:
- Refill at i_addr=0x8000_1234 with 16 R beats, rresp=0, rlast on beat 15 -> araddr=0x8000_1200, arlen=15, arsize=2, arburst=1; 16 write_en pulses; o_done at +1 cycle; o_err=0.
- Writeback, i_wready toggling 1/0 every cycle -> 16 W handshakes; wlast only on 16th; write_en exactly on handshakes; bresp=0 -> o_done, o_err=0.
- i_wb_req and i_fill_req both high in IDLE -> AW issued first, no AR; fill ignored until DONE.
- Refill with rresp=2 on beat 5 -> all 16 beats accepted; o_err=1 at o_done.
- rlast early on beat 9 -> exit after beat 9; o_err=1.
- arst pulse during W beat 7 -> next cycle IDLE: o_wvalid=0, o_start_write=0, o_busy=0; a new request is accepted normally.
